// File: rtl/ysyx_040750_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and their W variants.
// Retires one quotient bit per cycle. The result is held until the consumer accepts it, and a flush aborts the operation.
module ysyx_040750_div_unit #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             I_sys_clk,
  input  logic             I_rst,
  input  logic             I_div_valid,
  output logic             O_div_ready,
  input  logic [WIDTH-1:0] I_dividend,
  input  logic [WIDTH-1:0] I_divisor,
  input  logic             I_div_signed,
  input  logic             I_div_word,
  input  logic             I_rem_sel,
  input  logic             I_flush,
  output logic             O_out_valid,
  input  logic             I_out_ready,
  output logic [WIDTH-1:0] O_result,
  output logic             O_busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned WW = 32;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] pr;
  logic [WIDTH-1:0]   dsr;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      last;
  logic               q_neg;
  logic               r_neg;
  logic               rem_q;
  logic               word_q;

  logic [WIDTH-1:0]   a_ext, b_ext, a_abs, b_abs, min_neg, spec_res;
  logic [WIDTH-1:0]   quot, rem, q_fix, r_fix, sel, fin_res;
  logic               a_neg, b_neg, div_zero, ovf, ge;
  logic [WIDTH:0]     top, diff;
  logic [2*WIDTH-1:0] pr_next, pr_load;

  function automatic logic [WIDTH-1:0] sext_w(input logic [WIDTH-1:0] x);
    return {{(WIDTH-WW){x[WW-1]}}, x[WW-1:0]};
  endfunction

  // Operand conditioning, special-case detection and one restoring step
  always_comb begin
    a_ext = I_dividend;
    b_ext = I_divisor;
    if (I_div_word) begin
      a_ext = I_div_signed ? sext_w(I_dividend) : {{(WIDTH-WW){1'b0}}, I_dividend[WW-1:0]};
      b_ext = I_div_signed ? sext_w(I_divisor)  : {{(WIDTH-WW){1'b0}}, I_divisor[WW-1:0]};
    end
    a_neg   = I_div_signed & a_ext[WIDTH-1];
    b_neg   = I_div_signed & b_ext[WIDTH-1];
    a_abs   = a_neg ? -a_ext : a_ext;
    b_abs   = b_neg ? -b_ext : b_ext;
    min_neg = I_div_word ? {{(WIDTH-WW+1){1'b1}}, {(WW-1){1'b0}}} : {1'b1, {(WIDTH-1){1'b0}}};
    div_zero = (b_ext == '0);
    ovf      = I_div_signed & (a_ext == min_neg) & (b_ext == '1);
    if (div_zero) spec_res = I_rem_sel ? a_ext : '1;
    else          spec_res = I_rem_sel ? '0 : a_ext;
    if (I_div_word) spec_res = sext_w(spec_res);
    // Word dividends sit at the top of the low half so 32 shifts fully consume them.
    pr_load = I_div_word ? {{WIDTH{1'b0}}, a_abs[WW-1:0], {(WIDTH-WW){1'b0}}}
                         : {{WIDTH{1'b0}}, a_abs};

    top     = pr[2*WIDTH-1:WIDTH-1];
    diff    = top - {1'b0, dsr};
    ge      = ~diff[WIDTH];
    pr_next = {(ge ? diff[WIDTH-1:0] : top[WIDTH-1:0]), pr[WIDTH-2:0], ge};
    quot    = pr_next[WIDTH-1:0];
    rem     = pr_next[2*WIDTH-1:WIDTH];
    q_fix   = q_neg ? -quot : quot;
    r_fix   = r_neg ? -rem : rem;
    sel     = rem_q ? r_fix : q_fix;
    fin_res = word_q ? sext_w(sel) : sel;
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      state       <= IDLE;
      pr          <= '0;
      dsr         <= '0;
      cnt         <= '0;
      last        <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      rem_q       <= 1'b0;
      word_q      <= 1'b0;
      O_div_ready <= 1'b1;
      O_busy      <= 1'b0;
      O_out_valid <= 1'b0;
      O_result    <= '0;
    end else if (I_flush) begin
      state       <= IDLE;
      O_div_ready <= 1'b1;
      O_busy      <= 1'b0;
      O_out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (I_div_valid) begin
            q_neg       <= a_neg ^ b_neg;
            r_neg       <= a_neg;
            rem_q       <= I_rem_sel;
            word_q      <= I_div_word;
            dsr         <= b_abs;
            pr          <= pr_load;
            cnt         <= '0;
            last        <= I_div_word ? CW'(WW-1) : CW'(WIDTH-1);
            O_div_ready <= 1'b0;
            O_busy      <= 1'b1;
            if (div_zero | ovf) begin
              O_result    <= spec_res;
              O_out_valid <= 1'b1;
              state       <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          pr  <= pr_next;
          cnt <= cnt + CW'(1);
          // The last iteration also applies signs so the result is registered with no extra cycle.
          if (cnt == last) begin
            O_result    <= fin_res;
            O_out_valid <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (I_out_ready) begin
            O_out_valid <= 1'b0;
            O_div_ready <= 1'b1;
            O_busy      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_040750_div_unit.sv
// Directed bench for ysyx_040750_div_unit. It checks table vectors for value and latency, then flush, hold and reset sequences.
module tb_ysyx_040750_div_unit;

  logic        clk = 1'b0;
  logic        rst, div_valid, div_ready, div_signed, div_word, rem_sel;
  logic        flush, out_valid, out_ready, busy;
  logic [63:0] dividend, divisor, result;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  ysyx_040750_div_unit #(.WIDTH(64)) dut (
    .I_sys_clk   (clk),
    .I_rst       (rst),
    .I_div_valid (div_valid),
    .O_div_ready (div_ready),
    .I_dividend  (dividend),
    .I_divisor   (divisor),
    .I_div_signed(div_signed),
    .I_div_word  (div_word),
    .I_rem_sel   (rem_sel),
    .I_flush     (flush),
    .O_out_valid (out_valid),
    .I_out_ready (out_ready),
    .O_result    (result),
    .O_busy      (busy)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sgn;
    logic        word;
    logic        rem;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%016h expected=0x%016h", nm, got, exp);
    end
  endtask

  task automatic check_idle(input string nm);
    check(nm, {61'd0, div_ready, busy, out_valid}, 64'd4);
  endtask

  task automatic run_op(input string nm, input logic [63:0] a, input logic [63:0] b,
                        input logic sg, input logic wd, input logic rs,
                        input logic [63:0] exp, input int exp_lat, input int hold);
    int          lat;
    logic        busy_ok;
    logic        stable;
    logic [63:0] r0;
    @(negedge clk);
    check({nm, "_ready"}, 64'(div_ready), 64'd1);
    dividend = a; divisor = b; div_signed = sg; div_word = wd; rem_sel = rs;
    div_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    busy_ok = 1'b1;
    @(negedge clk);
    div_valid = 1'b0;
    // Scramble inputs; only the values sampled at accept may matter.
    dividend = ~a; divisor = ~b; div_signed = ~sg; div_word = ~wd; rem_sel = ~rs;
    while (!out_valid && lat < 200) begin
      busy_ok &= busy;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    busy_ok &= busy;
    check({nm, "_lat"}, 64'(lat), 64'(exp_lat));
    check({nm, "_res"}, result, exp);
    check({nm, "_busy"}, 64'(busy_ok), 64'd1);
    if (hold > 0) begin
      r0 = result;
      stable = 1'b1;
      repeat (hold) begin
        @(posedge clk);
        @(negedge clk);
        stable &= out_valid & busy & (result === r0);
      end
      check({nm, "_hold"}, 64'(stable), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_idle({nm, "_idle"});
  endtask

  initial begin
    rst = 1'b1; div_valid = 1'b0; dividend = '0; divisor = '0;
    div_signed = 1'b0; div_word = 1'b0; rem_sel = 1'b0; flush = 1'b0; out_ready = 1'b0;

    vecs.push_back('{64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14, 65});
    vecs.push_back('{64'd100, 64'd7, 1'b0, 1'b0, 1'b1, 64'd2, 65});
    vecs.push_back('{-64'sd7, 64'd2, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 65});
    vecs.push_back('{-64'sd7, 64'd2, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 65});
    vecs.push_back('{64'd7, -64'sd2, 1'b1, 1'b0, 1'b1, 64'd1, 65});
    vecs.push_back('{64'd5, 64'd0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1});
    vecs.push_back('{-64'sd5, 64'd0, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 1});
    vecs.push_back('{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1});
    vecs.push_back('{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 64'd0, 1});
    vecs.push_back('{64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000, 1});
    vecs.push_back('{64'h1_FFFF_FFFE, 64'd2, 1'b0, 1'b1, 1'b0, 64'h0000_0000_7FFF_FFFF, 33});
    vecs.push_back('{64'hFFFF_FFFF, 64'h10, 1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_000F, 33});
    vecs.push_back('{64'hFFFF_FFFF, 64'd1, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 33});
    vecs.push_back('{64'hAAAA_0000_8000_0005, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0005, 1});
    vecs.push_back('{64'h1234_5678_FFFF_FF9C, 64'd7, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF2, 33});
    vecs.push_back('{64'h1234_5678_FFFF_FF9C, 64'd7, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 33});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0, 1'b0, 1'b0, 64'h5555_5555_5555_5555, 65});
    vecs.push_back('{64'h8000_0000_0000_0000, 64'd2, 1'b1, 1'b0, 1'b0, 64'hC000_0000_0000_0000, 65});

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle("reset_flags");
    check("reset_result", result, 64'd0);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].word,
             vecs[i].rem, vecs[i].exp, vecs[i].lat, 0);

    // Flush before the 20th iteration edge, then restart one cycle later.
    @(negedge clk);
    dividend = 64'd100; divisor = 64'd7; div_signed = 1'b0; div_word = 1'b0; rem_sel = 1'b0;
    div_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div_valid = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check_idle("flush_idle");
    begin
      logic quiet;
      quiet = 1'b1;
      repeat (70) begin
        @(posedge clk);
        @(negedge clk);
        quiet &= ~out_valid & ~busy;
      end
      check("flush_no_valid", 64'(quiet), 64'd1);
    end
    run_op("after_flush", 64'd1000, 64'd9, 1'b0, 1'b0, 1'b1, 64'd1, 65, 0);

    run_op("hold", -64'sd7, 64'd2, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 65, 10);

    // Reset in the middle of an iteration sequence.
    @(negedge clk);
    dividend = 64'd12345; divisor = 64'd11; div_signed = 1'b0; div_word = 1'b0; rem_sel = 1'b0;
    div_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    div_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("calc_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle("rst_calc_flags");
    check("rst_calc_result", result, 64'd0);

    run_op("after_rst", 64'd12345, 64'd11, 1'b0, 1'b0, 1'b0, 64'd1122, 65, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
